// File: rtl/prach_pack.sv
// prach_pack: pairs the DDC's TDM I/Q samples per stream, packs four IQ
// pairs into each 128-bit beat, buffers the beats in a FIFO and emits
// fixed-length Avalon-ST packets tagged with the stream index.
//
// Output handshake: a beat transfers on any clk_dsp edge where
// avst_source_valid && avst_source_ready (readyLatency 0). While valid is
// high and ready is low, data/channel/sop/eop stay unchanged.
module prach_pack #(
  parameter int NUM_STREAM = 8,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int PKT_LEN_W  = 12
) (
  input  logic                              clk_dsp,
  input  logic                              rst_dsp_n,
  input  logic                              din_sync,
  input  logic                              din_dv,
  input  logic [$clog2(2*NUM_STREAM)-1:0]   din_chn,
  input  logic [DW-1:0]                     din_dq,
  input  logic [NUM_STREAM-1:0]             ctrl_enable,
  input  logic [PKT_LEN_W-1:0]              cfg_pkt_len,
  output logic [127:0]                      avst_source_data,
  output logic                              avst_source_valid,
  output logic [15:0]                       avst_source_channel,
  output logic                              avst_source_startofpacket,
  output logic                              avst_source_endofpacket,
  input  logic                              avst_source_ready,
  output logic                              stat_overflow,
  input  logic                              stat_overflow_clr
);

  localparam int CW = $clog2(2*NUM_STREAM);
  localparam int SW = (NUM_STREAM > 1) ? $clog2(NUM_STREAM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2*DW;
  localparam int BW = 4*PW;
  localparam int TW = BW + SW + 2;   // FIFO entry: {data, channel, sop, eop}

  // Active configuration and per-stream pack state
  logic [NUM_STREAM-1:0] en_q, resync_q;
  logic [PKT_LEN_W-1:0]  len_q;
  logic [DW-1:0]         held_i_q [NUM_STREAM];
  logic                  held_v_q [NUM_STREAM];
  logic [1:0]            pc_q     [NUM_STREAM];
  logic [PKT_LEN_W-1:0]  bc_q     [NUM_STREAM];
  logic [3*PW-1:0]       acc_q    [NUM_STREAM];

  // Completed-beat stage (one beat at most per cycle)
  logic          wr_v_q, wr_sop_q, wr_eop_q;
  logic [BW-1:0] wr_data_q;
  logic [SW-1:0] wr_ch_q;

  // FIFO: out_ent_q is the registered head, mem holds the rest
  logic [TW-1:0] mem [FIFO_DEPTH];
  logic [TW-1:0] out_ent_q, out_ent_d, wr_ent;
  logic          out_v_q, out_v_d;
  logic [AW:0]   mcnt_q, mcnt_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic          ovf_q;

  // Sample decode; a sync in the same cycle makes the sample see cleared state
  logic                  is_q, held_v_eff, rs_eff, take, take_i, take_q;
  logic                  beat_done, beat_sop, beat_eop;
  logic [SW-1:0]         sid;
  logic [NUM_STREAM-1:0] en_eff;
  logic [PKT_LEN_W-1:0]  len_eff, last_bc, bc_eff;
  logic [1:0]            pc_eff;
  logic [PW-1:0]         pair;

  assign is_q       = din_chn >= CW'(NUM_STREAM);
  assign sid        = is_q ? SW'(din_chn - CW'(NUM_STREAM)) : SW'(din_chn);
  assign en_eff     = din_sync ? ctrl_enable : en_q;
  assign len_eff    = din_sync ? cfg_pkt_len : len_q;
  assign last_bc    = (len_eff == '0) ? '0 : len_eff - 1'b1;  // length 0 acts as 1
  assign held_v_eff = din_sync ? 1'b0 : held_v_q[sid];
  assign rs_eff     = din_sync ? 1'b0 : resync_q[sid];
  assign pc_eff     = din_sync ? 2'd0 : pc_q[sid];
  assign bc_eff     = din_sync ? '0   : bc_q[sid];
  assign take       = din_dv && en_eff[sid] && !rs_eff;
  assign take_i     = take && !is_q;
  assign take_q     = take && is_q && held_v_eff;   // orphan Q is dropped
  assign pair       = {held_i_q[sid], din_dq};
  assign beat_done  = take_q && (pc_eff == 2'd3);
  assign beat_sop   = (bc_eff == '0);
  assign beat_eop   = (bc_eff == last_bc);

  // FIFO control; a pop in the same cycle frees the slot for the write
  logic pop, out_free, full, ovf_drop, mem_rd, mem_wr, to_out;
  assign pop      = out_v_q && avst_source_ready;
  assign out_free = !out_v_q || pop;
  assign full     = !out_free && (mcnt_q == (AW+1)'(FIFO_DEPTH-1));
  assign ovf_drop = wr_v_q && full;
  assign mem_rd   = out_free && (mcnt_q != '0);
  assign to_out   = out_free && (mcnt_q == '0) && wr_v_q;
  assign mem_wr   = wr_v_q && !full && !to_out;
  assign wr_ent   = {wr_data_q, wr_ch_q, wr_sop_q, wr_eop_q};
  assign mcnt_d   = mcnt_q + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);

  // Sync handling, overflow resync, I holding, pairing and beat counting
  always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
    if (!rst_dsp_n) begin
      en_q     <= '0;
      resync_q <= '0;
      len_q    <= '0;
      for (int s = 0; s < NUM_STREAM; s++) begin
        held_i_q[s] <= '0;
        held_v_q[s] <= 1'b0;
        pc_q[s]     <= '0;
        bc_q[s]     <= '0;
        acc_q[s]    <= '0;
      end
    end else begin
      if (din_sync) begin
        en_q     <= ctrl_enable;
        len_q    <= cfg_pkt_len;
        resync_q <= '0;
        for (int s = 0; s < NUM_STREAM; s++) begin
          held_i_q[s] <= '0;
          held_v_q[s] <= 1'b0;
          pc_q[s]     <= '0;
          bc_q[s]     <= '0;
        end
      end else if (ovf_drop) begin
        resync_q[wr_ch_q] <= 1'b1;
      end
      if (take_i) begin
        held_i_q[sid] <= din_dq;
        held_v_q[sid] <= 1'b1;
      end
      if (take_q) begin
        held_v_q[sid] <= 1'b0;
        acc_q[sid]    <= {acc_q[sid][2*PW-1:0], pair};
        pc_q[sid]     <= pc_eff + 2'd1;
        if (beat_done) bc_q[sid] <= beat_eop ? '0 : bc_eff + 1'b1;
      end
    end
  end

  // Register the completed beat and its tag for the FIFO write next cycle
  always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
    if (!rst_dsp_n) begin
      wr_v_q    <= 1'b0;
      wr_data_q <= '0;
      wr_ch_q   <= '0;
      wr_sop_q  <= 1'b0;
      wr_eop_q  <= 1'b0;
    end else begin
      wr_v_q <= beat_done;
      if (beat_done) begin
        wr_data_q <= {acc_q[sid], pair};
        wr_ch_q   <= sid;
        wr_sop_q  <= beat_sop;
        wr_eop_q  <= beat_eop;
      end
    end
  end

  // Next head register: refill from memory first, else bypass the new beat
  always_comb begin
    out_v_d   = out_v_q;
    out_ent_d = out_ent_q;
    if (out_free) begin
      if (mem_rd) begin
        out_v_d   = 1'b1;
        out_ent_d = mem[rptr_q];
      end else if (to_out) begin
        out_v_d   = 1'b1;
        out_ent_d = wr_ent;
      end else begin
        out_v_d   = 1'b0;
        out_ent_d = '0;
      end
    end
  end

  // FIFO storage array (no reset needed: contents gated by the count)
  always_ff @(posedge clk_dsp) begin
    if (mem_wr) mem[wptr_q] <= wr_ent;
  end

  // FIFO pointers, count, head register and sticky overflow flag
  always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
    if (!rst_dsp_n) begin
      out_v_q   <= 1'b0;
      out_ent_q <= '0;
      mcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      out_v_q   <= out_v_d;
      out_ent_q <= out_ent_d;
      mcnt_q    <= mcnt_d;
      if (mem_wr) wptr_q <= wptr_q + 1'b1;
      if (mem_rd) rptr_q <= rptr_q + 1'b1;
      if (ovf_drop)               ovf_q <= 1'b1;
      else if (stat_overflow_clr) ovf_q <= 1'b0;
    end
  end

  assign avst_source_valid         = out_v_q;
  assign avst_source_data          = out_ent_q[TW-1 -: BW];
  assign avst_source_channel       = 16'(out_ent_q[SW+1:2]);
  assign avst_source_startofpacket = out_ent_q[1];
  assign avst_source_endofpacket   = out_ent_q[0];
  assign stat_overflow             = ovf_q;

endmodule
